spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
Sits between the SPI slave's 10-bit command interface and a single-port synchronous RAM. It also shares that RAM with a local host port.
- Decodes SPI command words (address latch, write, read) into RAM transactions.
- Arbitrates the RAM between the SPI path and the host.
- Returns SPI read data to the slave on tx_data/tx_valid.

Parameters:
ADDR_WIDTH, 8, RAM address width; legal range 1..8, taken from the low bits of the SPI payload.
DATA_WIDTH, 8, RAM/host data width; fixed at 8 to match the SPI payload.
FAIR, 1, 1 = round-robin between SPI and host; 0 = fixed SPI priority.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
rx_valid  in  1  one-cycle pulse from SPI slave, rx_data valid
rx_data  in  10  [9:8] command, [7:0] payload
tx_valid  out  1  SPI read data ready, level
tx_data  out  8  SPI read data
host_req  in  1  host request; level, held until host_gnt
host_we  in  1  1 = write, 0 = read; stable while host_req
host_addr  in  ADDR_WIDTH  host address; stable while host_req
host_wdata  in  8  host write data; stable while host_req
host_gnt  out  1  one-cycle grant
host_rvalid  out  1  one-cycle host read data valid
host_rdata  out  8  host read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data; valid one cycle after ram_en with ram_we = 0
spi_ovf  out  1  sticky: SPI request dropped
busy  out  1  state != ARB or SPI pending

Behaviour:
- Reset: state ARB; wr_addr = 0, rd_addr = 0; SPI pending cleared; last-grant = HOST.
- Reset values of outputs: tx_valid = 0, tx_data = 0, spi_ovf = 0; all RAM and host outputs 0.
- Reset mid-operation aborts any access. An in-flight read never produces tx_valid or host_rvalid.
- SPI decode, on rx_valid:
  - 00: wr_addr <= payload.
  - 10: rd_addr <= payload.
  - 01: post a pending write {addr = wr_addr, data = payload}.
  - 11: post a pending read {addr = rd_addr}; the payload is a dummy and is ignored.
- Address commands never touch the pending register. The address is captured into the pending entry at post time; later address commands do not affect it.
- Pending register: one entry.
  - Post while occupied and not being granted this cycle → new request dropped, spi_ovf <= 1.
  - Post in the same cycle the entry is granted → accepted, no overflow.
- FSM states: ARB, ACCESS, CAPTURE.
  - ARB: if no requester, stay. Otherwise pick the owner, latch owner/op/addr/data, go to ACCESS. An SPI request posted this cycle is first visible next cycle.
  - Arbitration, both requesting: FAIR = 1 grants the one not granted last; FAIR = 0 grants SPI. Only one requesting: grant it.
  - ACCESS: lasts exactly 1 cycle; ram_en = 1, ram_we = op.
    - Host owner: host_gnt = 1 this cycle.
    - SPI owner: pending cleared at end of cycle.
    - Write → ARB. Read → CAPTURE.
  - CAPTURE: lasts 1 cycle, then ARB.
    - Host owner: host_rvalid = 1, host_rdata = ram_rdata.
    - SPI owner: tx_data <= ram_rdata, tx_valid <= 1 at end of cycle.
- tx_valid stays high until the next rx_valid pulse clears it. If set and clear coincide, set wins.
- Latency, no contention, rx_valid sampled at edge E0:
  - ram_en high in the cycle after E1.
  - RAM write occurs at E2.
  - tx_valid rises at E3.
- Host latency: gnt ≥1 cycle after req is seen in ARB; rvalid exactly 1 cycle after gnt.
- Throughput: write 2 cycles per access, read 3 cycles per access.
- Addresses use payload[ADDR_WIDTH-1:0]; upper bits are ignored.

Optional Feature:
SPI_RD_AUTOINC_EN:
- Defined: each granted SPI read increments rd_addr by 1 at the end of ACCESS, wrapping 2^ADDR_WIDTH-1 → 0. A 10-command in the same cycle overrides the increment.
- Undefined: rd_addr changes only on a 10-command.

Test Plan:
1. SPI 0x005, 0x1A5, 0x205, 0x300 → RAM[5] = 0xA5; tx_valid rises 3 clocks after the 0x300 pulse with tx_data = 0xA5; the next rx_valid clears tx_valid.
2. Host write addr 0x10 data 0x3C, then host read 0x10 → host_gnt each time; host_rvalid 1 cycle after the second gnt; host_rdata = 0x3C.
3. FAIR = 1: SPI write pending and host_req in the same ARB cycle, last grant HOST → SPI first, host next. Repeated contention alternates. With FAIR = 0, SPI always wins.
4. Two 01-commands back-to-back while host holds the RAM → second dropped, spi_ovf = 1 and stays 1; only the first write lands.
5. Assert rst_n low during ACCESS of an SPI read → no tx_valid; outputs return to reset values; spi_ovf = 0. A fresh transaction afterwards completes normally.
6. SPI_RD_AUTOINC_EN, rd_addr = 0xFF → three 0x300 reads return RAM[0xFF], RAM[0x00], RAM[0x01].

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes 10-bit SPI command words into RAM accesses and
// shares a single-port synchronous RAM between the SPI path and a host port.
// Optional build macro: SPI_RD_AUTOINC_EN -- each granted SPI read advances
// rd_addr by one (wrapping); otherwise rd_addr moves only on an address command.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FAIR       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [9:0]            rx_data,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  spi_ovf,
  output logic                  busy
);

`ifdef SPI_RD_AUTOINC_EN
  localparam bit RD_AUTOINC = 1'b1;
`else
  localparam bit RD_AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {ARB, ACCESS, CAPTURE} state_t;
  localparam logic OWN_SPI  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic                  pend_valid_q, pend_we_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [DATA_WIDTH-1:0] pend_data_q;
  logic                  owner_q, op_we_q, last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q, ovf_q;
  logic                  arb_take, arb_spi;

  // Command bit 8 set means a RAM request (01 write, 11 read); bit 9 picks read.
  logic                  post, set_wr_addr, set_rd_addr, spi_grant_now, spi_wins;
  logic [ADDR_WIDTH-1:0] payload_addr;

  assign post          = rx_valid && rx_data[8];
  assign set_wr_addr   = rx_valid && (rx_data[9:8] == 2'b00);
  assign set_rd_addr   = rx_valid && (rx_data[9:8] == 2'b10);
  assign payload_addr  = rx_data[ADDR_WIDTH-1:0];
  assign spi_grant_now = (state_q == ACCESS) && (owner_q == OWN_SPI);
  // With both requesting, fair mode alternates; otherwise SPI has priority.
  assign spi_wins      = pend_valid_q && (!host_req || (FAIR == 0) || (last_q == OWN_HOST));

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign spi_ovf  = ovf_q;
  assign busy     = (state_q != ARB) || pend_valid_q;

  // Next-state decode and per-state RAM/host strobes.
  always_comb begin
    state_d     = state_q;
    arb_take    = 1'b0;
    arb_spi     = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    host_rdata  = '0;
    case (state_q)
      ARB: begin
        if (pend_valid_q || host_req) begin
          arb_take = 1'b1;
          arb_spi  = spi_wins;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        ram_en    = 1'b1;
        ram_we    = op_we_q;
        ram_addr  = addr_q;
        ram_wdata = data_q;
        host_gnt  = (owner_q == OWN_HOST);
        state_d   = op_we_q ? ARB : CAPTURE;
      end
      CAPTURE: begin
        if (owner_q == OWN_HOST) begin
          host_rvalid = 1'b1;
          host_rdata  = ram_rdata;
        end
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // State register plus the transaction latched when arbitration picks an owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      owner_q <= OWN_SPI;
      op_we_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= OWN_HOST;
    end else begin
      state_q <= state_d;
      if (arb_take) begin
        owner_q <= arb_spi ? OWN_SPI : OWN_HOST;
        op_we_q <= arb_spi ? pend_we_q : host_we;
        addr_q  <= arb_spi ? pend_addr_q : host_addr;
        data_q  <= arb_spi ? pend_data_q : host_wdata;
        last_q  <= arb_spi ? OWN_SPI : OWN_HOST;
      end
    end
  end

  // SPI address registers and the single-entry pending request with overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      if (set_wr_addr) wr_addr_q <= payload_addr;
      if (set_rd_addr) rd_addr_q <= payload_addr;
      else if (RD_AUTOINC && spi_grant_now && !op_we_q) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
      // The slot frees at the end of the SPI ACCESS cycle, so a post in that cycle is kept.
      if (post && (!pend_valid_q || spi_grant_now)) begin
        pend_valid_q <= 1'b1;
        pend_we_q    <= !rx_data[9];
        pend_addr_q  <= rx_data[9] ? rd_addr_q : wr_addr_q;
        pend_data_q  <= rx_data[DATA_WIDTH-1:0];
      end else if (spi_grant_now) begin
        pend_valid_q <= 1'b0;
      end
      if (post && pend_valid_q && !spi_grant_now) ovf_q <= 1'b1;
    end
  end

  // SPI read return: set at the end of CAPTURE, cleared by the next command pulse; set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else if ((state_q == CAPTURE) && (owner_q == OWN_SPI)) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= ram_rdata;
    end else if (rx_valid) begin
      tx_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: vector table, hand-timed corner
// sequences, and a randomized run against a memory-level reference model.
module tb_spi_ram_arbiter;
  localparam int AW      = 8;
  localparam int TB_FAIR = 1;

  logic       clk, rst_n, rx_valid, tx_valid, host_req, host_we, host_gnt, host_rvalid;
  logic [9:0] rx_data;
  logic [7:0] tx_data, host_addr, host_wdata, host_rdata, ram_addr, ram_wdata, ram_rdata;
  logic       ram_en, ram_we, spi_ovf, busy;

  spi_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(8), .FAIR(TB_FAIR)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .spi_ovf(spi_ovf), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM attached to the DUT.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: memory contents and the two SPI address pointers.
  logic [7:0] ref_mem [256];
  bit         ref_known [256];
  logic [7:0] ref_wr = 8'h00;
  logic [7:0] ref_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_spi(input logic [9:0] w, output bit is_rd, output bit known,
                           output logic [7:0] exp);
    is_rd = 1'b0; known = 1'b0; exp = 8'h00;
    case (w[9:8])
      2'b00: ref_wr = w[7:0];
      2'b10: ref_rd = w[7:0];
      2'b01: begin ref_mem[ref_wr] = w[7:0]; ref_known[ref_wr] = 1'b1; end
      default: begin
        is_rd = 1'b1; known = ref_known[ref_rd]; exp = ref_mem[ref_rd];
`ifdef SPI_RD_AUTOINC_EN
        ref_rd = ref_rd + 8'd1;
`endif
      end
    endcase
  endtask

  task automatic spi_send(input logic [9:0] w);
    rx_data = w; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin @(posedge clk); #1; k++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic spi_op(input logic [9:0] w);
    bit is_rd, known; logic [7:0] exp;
    spi_send(w);
    wait_idle();
    model_spi(w, is_rd, known, exp);
    chk("spi_tx_valid", tx_valid, is_rd);
    if (is_rd && known) chk("spi_tx_data", tx_data, exp);
  endtask

  task automatic host_op(input bit we, input logic [7:0] a, input logic [7:0] d);
    int k = 0;
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    do begin @(posedge clk); #1; k++; end while (!host_gnt && k < 50);
    chk("host_gnt", host_gnt, 1);
    chk("host_ram_addr", ram_addr, a);
    host_req = 1'b0;
    @(posedge clk); #1;
    chk("host_gnt_pulse", host_gnt, 0);
    chk("host_rvalid", host_rvalid, !we);
    if (we) begin ref_mem[a] = d; ref_known[a] = 1'b1; end
    else if (ref_known[a]) chk("host_rdata", host_rdata, ref_mem[a]);
  endtask

  // Post an SPI write and raise host_req so both are seen in the same ARB cycle.
  task automatic contend(input bit prior_spi, input logic [7:0] hv, input logic [7:0] sv);
    int ord [2];
    int n = 0, k = 0;
    bit d1, d2; logic [7:0] d3;
    bit host_first;
    ord[0] = -1; ord[1] = -1;
    if (prior_spi) spi_op({2'b01, ~sv});
    else host_op(1'b1, 8'h50, ~hv);
    host_we = 1'b1; host_addr = 8'h50; host_wdata = hv;
    spi_send({2'b01, sv});
    host_req = 1'b1;
    while (n < 2 && k < 20) begin
      @(posedge clk); #1; k++;
      if (ram_en) begin
        ord[n] = host_gnt ? 1 : 0;
        n++;
        if (host_gnt) host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    host_first = (TB_FAIR != 0) && prior_spi;
    chk("contend_first_host", ord[0], host_first);
    chk("contend_second_host", ord[1], !host_first);
    wait_idle();
    ref_mem[8'h50] = hv; ref_known[8'h50] = 1'b1;
    model_spi({2'b01, sv}, d1, d2, d3);
  endtask

  typedef struct {
    logic [9:0] w;
    bit         exp_txv;
    logic [7:0] exp_txd;
  } vec_t;

  initial begin
    vec_t       vt [14];
    bit         is_rd, known;
    logic [7:0] exp;
    logic [7:0] autoinc_exp [3];

    vt[0]  = '{10'h005, 1'b0, 8'h00};
    vt[1]  = '{10'h1A5, 1'b0, 8'h00};
    vt[2]  = '{10'h205, 1'b0, 8'h00};
    vt[3]  = '{10'h300, 1'b1, 8'hA5};
    vt[4]  = '{10'h033, 1'b0, 8'h00};
    vt[5]  = '{10'h15A, 1'b0, 8'h00};
    vt[6]  = '{10'h233, 1'b0, 8'h00};
    vt[7]  = '{10'h3FF, 1'b1, 8'h5A};
    vt[8]  = '{10'h205, 1'b0, 8'h00};
    vt[9]  = '{10'h377, 1'b1, 8'hA5};
    vt[10] = '{10'h000, 1'b0, 8'h00};
    vt[11] = '{10'h1C3, 1'b0, 8'h00};
    vt[12] = '{10'h200, 1'b0, 8'h00};
    vt[13] = '{10'h300, 1'b1, 8'hC3};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {tx_valid, tx_data, spi_ovf, ram_en, ram_we, ram_addr, ram_wdata,
         host_gnt, host_rvalid, host_rdata, busy}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: command words with the read data each one must return.
    for (int i = 0; i < 14; i++) begin
      spi_send(vt[i].w);
      wait_idle();
      model_spi(vt[i].w, is_rd, known, exp);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid, vt[i].exp_txv);
      if (vt[i].exp_txv) chk($sformatf("vec%0d_tx_data", i), tx_data, vt[i].exp_txd);
    end

    // Read latency: ram_en after E1, tx_valid at E3, cleared by the next pulse.
    spi_op(10'h205);
    spi_send(10'h300);
    model_spi(10'h300, is_rd, known, exp);
    chk("lat_e0_tx_valid", tx_valid, 0);
    chk("lat_e0_ram_en", ram_en, 0);
    @(posedge clk); #1;
    chk("lat_e1_ram_access", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h05});
    @(posedge clk); #1;
    chk("lat_e2_tx_valid", tx_valid, 0);
    @(posedge clk); #1;
    chk("lat_e3_tx_valid", tx_valid, 1);
    chk("lat_e3_tx_data", tx_data, exp);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_tx_valid_level", tx_valid, 1);
    spi_op(10'h205);

    // Host write then read.
    host_op(1'b1, 8'h10, 8'h3C);
    host_op(1'b0, 8'h10, 8'h00);

    // Contention: SPI first after a host grant, host first after an SPI grant.
    spi_op(10'h060);
    contend(1'b0, 8'h61, 8'h62);
    contend(1'b1, 8'h63, 8'h64);

    // Overflow: second write posted while the first still waits behind a host read.
    spi_op(10'h070);
    host_we = 1'b0; host_addr = 8'h50; host_req = 1'b1;
    @(posedge clk); #1;
    chk("ovf_host_gnt", host_gnt, 1);
    host_req = 1'b0;
    rx_data = {2'b01, 8'hD1}; rx_valid = 1'b1;
    @(posedge clk); #1;
    chk("ovf_host_rvalid", host_rvalid, 1);
    chk("ovf_host_rdata", host_rdata, ref_mem[8'h50]);
    chk("ovf_not_yet", spi_ovf, 0);
    rx_data = {2'b01, 8'hD2};
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("ovf_set", spi_ovf, 1);
    wait_idle();
    model_spi(10'h1D1, is_rd, known, exp);
    chk("ovf_first_write_only", mem[8'h70], 8'hD1);
    spi_op(10'h270);
    spi_op(10'h300);
    chk("ovf_sticky", spi_ovf, 1);

    // Reset during the ACCESS cycle of an SPI read.
    spi_op(10'h270);
    spi_send(10'h300);
    @(posedge clk); #1;
    chk("rst_in_access", {ram_en, ram_we}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs",
        {tx_valid, tx_data, spi_ovf, ram_en, ram_we, ram_addr, ram_wdata,
         host_gnt, host_rvalid, host_rdata, busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_tx_valid", tx_valid, 0);
    chk("rst_ovf_clear", spi_ovf, 0);
    ref_wr = 8'h00; ref_rd = 8'h00;
    spi_op(10'h270);
    spi_op(10'h300);

    // Read pointer wrap (or hold, when auto-increment is not built in).
    host_op(1'b1, 8'hFF, 8'h11);
    host_op(1'b1, 8'h00, 8'h22);
    host_op(1'b1, 8'h01, 8'h33);
`ifdef SPI_RD_AUTOINC_EN
    autoinc_exp[0] = 8'h11; autoinc_exp[1] = 8'h22; autoinc_exp[2] = 8'h33;
`else
    autoinc_exp[0] = 8'h11; autoinc_exp[1] = 8'h11; autoinc_exp[2] = 8'h11;
`endif
    spi_op(10'h2FF);
    for (int i = 0; i < 3; i++) begin
      spi_op(10'h300);
      chk($sformatf("rd_ptr_%0d", i), tx_data, autoinc_exp[i]);
    end

    // Randomized serial traffic over a small address window.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a, d;
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0: spi_op({2'b00, a});
        1: spi_op({2'b10, a});
        2: spi_op({2'b01, d});
        3: spi_op({2'b11, d});
        4: host_op(1'b1, a, d);
        default: host_op(1'b0, a, 8'h00);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule
